// File: rtl/level_to_pulse_debounce.sv
// level_to_pulse_debounce
//   Synchronises an asynchronous level through a 2-FF chain, debounces it with
//   a four-state FSM and emits registered single-cycle pulses on each accepted
//   change, together with the filtered level and a wrapping count of accepted
//   edges.
//
// Parameters
//   DEBOUNCE  consecutive synchronised samples needed to accept a change (>=1)
//   CNT_W     width of the accepted-edge counter
//
// Ports
//   clock       system clock, everything on the rising edge
//   reset       synchronous, active-high reset
//   level_in    asynchronous input level
//   pos         one-cycle pulse after an accepted 0->1 change
//   neg         one-cycle pulse after an accepted 1->0 change
//   level_out   debounced level
//   edge_count  number of accepted edges (pos + neg), wraps
module level_to_pulse_debounce #(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             level_in,
  output logic             pos,
  output logic             neg,
  output logic             level_out,
  output logic [CNT_W-1:0] edge_count
);

  localparam int CW = (DEBOUNCE + 1 > 1) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    LOW    = 2'd0,
    CHK_HI = 2'd1,
    HIGH   = 2'd2,
    CHK_LO = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          s1;
  logic          s2;

  // Synchroniser: the FSM only ever looks at s2.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= level_in;
      s2 <= s1;
    end
  end

  // Debounce FSM. pos/neg default low each cycle so any pulse lasts exactly
  // one cycle; level_out is registered alongside the state it reflects.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= LOW;
      cnt        <= '0;
      pos        <= 1'b0;
      neg        <= 1'b0;
      level_out  <= 1'b0;
      edge_count <= '0;
    end else begin
      pos <= 1'b0;
      neg <= 1'b0;
      case (state)
        LOW: begin
          if (s2) begin
            if (DEBOUNCE == 1) begin
              state      <= HIGH;
              level_out  <= 1'b1;
              pos        <= 1'b1;
              edge_count <= edge_count + 1'b1;
              cnt        <= '0;
            end else begin
              state <= CHK_HI;
              cnt   <= CW'(1);
            end
          end
        end
        CHK_HI: begin
          if (!s2) begin
            // Glitch rejected: fall back without any output change.
            state <= LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state      <= HIGH;
            level_out  <= 1'b1;
            pos        <= 1'b1;
            edge_count <= edge_count + 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HIGH: begin
          if (!s2) begin
            if (DEBOUNCE == 1) begin
              state      <= LOW;
              level_out  <= 1'b0;
              neg        <= 1'b1;
              edge_count <= edge_count + 1'b1;
              cnt        <= '0;
            end else begin
              state <= CHK_LO;
              cnt   <= CW'(1);
            end
          end
        end
        CHK_LO: begin
          if (s2) begin
            state <= HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state      <= LOW;
            level_out  <= 1'b0;
            neg        <= 1'b1;
            edge_count <= edge_count + 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_level_to_pulse_debounce.sv
// Testbench for level_to_pulse_debounce. Two instances share stimulus: the
// default configuration (DEBOUNCE=4, CNT_W=8) and a narrow one (DEBOUNCE=1,
// CNT_W=2) that exercises the single-sample path and counter wrap.
// The reference model counts the run of synchronised samples that disagree
// with the current filtered level and accepts a change when the run reaches
// DEBOUNCE.
module tb_level_to_pulse_debounce;

  localparam int W = 11;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic level_in = 1'b0;
  always #5 clock = ~clock;

  logic       pos_a, neg_a, lvl_a;
  logic [7:0] ec_a;
  logic       pos_b, neg_b, lvl_b;
  logic [1:0] ec_b;

  level_to_pulse_debounce #(.DEBOUNCE(4), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .level_in(level_in),
    .pos(pos_a), .neg(neg_a), .level_out(lvl_a), .edge_count(ec_a)
  );

  level_to_pulse_debounce #(.DEBOUNCE(1), .CNT_W(2)) dut_w (
    .clock(clock), .reset(reset), .level_in(level_in),
    .pos(pos_b), .neg(neg_b), .level_out(lvl_b), .edge_count(ec_b)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic s1, s2, lvl, pos, neg;
    int   run;
    int   ec;
  } mdl_t;

  function automatic mdl_t mdl_step(mdl_t m, logic rst, logic din, int deb, int cw);
    mdl_t n;
    n = m;
    if (rst) begin
      n.s1 = 0; n.s2 = 0; n.lvl = 0; n.pos = 0; n.neg = 0; n.run = 0; n.ec = 0;
    end else begin
      n.pos = 0;
      n.neg = 0;
      n.s1  = din;
      n.s2  = m.s1;
      n.run = (m.s2 != m.lvl) ? m.run + 1 : 0;
      if (n.run == deb) begin
        n.lvl = ~m.lvl;
        n.run = 0;
        if (m.lvl == 1'b0) n.pos = 1; else n.neg = 1;
        n.ec  = (m.ec + 1) % (1 << cw);
      end
    end
    return n;
  endfunction

  mdl_t m_a, m_b;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w_q[$];
  int n_checks = 0;
  int n_passed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    else
      n_passed++;
  endtask

  // per-phase observation counters (edge index relative to phase start)
  int cyc;
  int pos_cnt_a, neg_cnt_a, first_pos_a, first_neg_a;
  int pos_cnt_b, first_pos_b;

  task automatic phase_start();
    cyc = 0;
    pos_cnt_a = 0; neg_cnt_a = 0; first_pos_a = -1; first_neg_a = -1;
    pos_cnt_b = 0; first_pos_b = -1;
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of stimulus, predicts the post-edge outputs, then
  // samples the DUTs 1 time unit after the edge and compares.
  task automatic step(input logic rst, input logic din);
    logic [W-1:0] e;
    reset    = rst;
    level_in = din;
    @(posedge clock);
    m_a = mdl_step(m_a, rst, din, 4, 8);
    m_b = mdl_step(m_b, rst, din, 1, 2);
    exp_q.push_back({m_a.pos, m_a.neg, m_a.lvl, 8'(m_a.ec)});
    exp_w_q.push_back({m_b.pos, m_b.neg, m_b.lvl, 6'd0, 2'(m_b.ec)});
    #1;
    e = exp_q.pop_front();
    check("dut_out", {21'd0, pos_a, neg_a, lvl_a, ec_a}, {21'd0, e});
    e = exp_w_q.pop_front();
    check("dut_w_out", {21'd0, pos_b, neg_b, lvl_b, 6'd0, ec_b}, {21'd0, e});
    if (pos_a) begin pos_cnt_a++; if (first_pos_a < 0) first_pos_a = cyc; end
    if (neg_a) begin neg_cnt_a++; if (first_neg_a < 0) first_neg_a = cyc; end
    if (pos_b) begin pos_cnt_b++; if (first_pos_b < 0) first_pos_b = cyc; end
    cyc++;
  endtask

  task automatic hold(input logic din, input int n);
    for (int i = 0; i < n; i++) step(1'b0, din);
  endtask

  int wrap_exp[5] = '{1, 2, 3, 0, 1};

  initial begin
    m_a = '{s1:0, s2:0, lvl:0, pos:0, neg:0, run:0, ec:0};
    m_b = m_a;

    // Reset held with level_in high: everything stays clear.
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check("rst_pos", {31'd0, pos_a}, 32'd0);
    check("rst_lvl", {31'd0, lvl_a}, 32'd0);
    check("rst_ec", {24'd0, ec_a}, 32'd0);

    // High at release counts as a rise: pos at edge DEBOUNCE+1.
    phase_start();
    hold(1'b1, 20);
    check("rise_pos_cnt", pos_cnt_a, 1);
    check("rise_pos_edge", first_pos_a, 5);
    check("rise_lvl", {31'd0, lvl_a}, 32'd1);
    check("d1_pos_edge", first_pos_b, 2);

    // Clean fall.
    phase_start();
    hold(1'b0, 12);
    check("fall_neg_cnt", neg_cnt_a, 1);
    check("fall_neg_edge", first_neg_a, 5);
    check("fall_ec", {24'd0, ec_a}, 32'd2);

    // 3-sample glitch rejected, 4-sample pulse accepted.
    phase_start();
    hold(1'b1, 3);
    hold(1'b0, 10);
    check("glitch3_pos", pos_cnt_a, 0);
    check("glitch3_ec", {24'd0, ec_a}, 32'd2);
    phase_start();
    hold(1'b1, 4);
    hold(1'b0, 10);
    check("pulse4_pos", pos_cnt_a, 1);
    check("pulse4_neg", neg_cnt_a, 1);

    // Bounce: 1,1,0,0 x5 then steady high.
    phase_start();
    for (int i = 0; i < 5; i++) begin
      hold(1'b1, 2);
      hold(1'b0, 2);
    end
    check("bounce_no_pos", pos_cnt_a, 0);
    phase_start();
    hold(1'b1, 12);
    check("bounce_pos_cnt", pos_cnt_a, 1);
    check("bounce_pos_edge", first_pos_a, 5);

    // Mid-debounce reset: rise starts, reset at edge 3, recount after release.
    hold(1'b0, 12);
    phase_start();
    hold(1'b1, 3);
    step(1'b1, 1'b1);
    check("midrst_no_pos", pos_cnt_a, 0);
    phase_start();
    hold(1'b1, 10);
    check("midrst_pos_cnt", pos_cnt_a, 1);
    check("midrst_pos_edge", first_pos_a, 5);

    // Counter wrap on the narrow instance.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    for (int t = 0; t < 5; t++) begin
      hold(((t % 2) == 0) ? 1'b1 : 1'b0, 4);
      check("wrap_ec", {30'd0, ec_b}, wrap_exp[t]);
    end

    // Random run lengths, checked cycle by cycle against the model.
    for (int r = 0; r < 60; r++)
      hold(1'($urandom_range(0, 1)), $urandom_range(1, 8));

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
